// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Generates the enable/clear controls for the F/D/E/M/W pipeline
//   registers (en=1 loads d, clear=1 loads 0). It merges four hazard sources:
//   load-use stalls, D-stage redirects, multi-cycle MDU stalls and M-stage
//   exception flushes. A small FSM and a shared counter track MDU occupancy,
//   which is bounded by a watchdog, and the length of an exception flush.
//
// Ports
//   clk          clock; all state updates on posedge
//   rst          synchronous reset, active-low
//   lw_hazard_d  load in E feeds an operand of the instruction in D
//   redirect_d   D-stage branch/jump taken; drop the wrong-path fetch
//   mdu_start_e  multi-cycle mul/div is in E this cycle
//   mdu_done     MDU result valid (single-cycle pulse)
//   exc_m        exception or eret committed in M
//   en_f..en_w   pipeline register enables
//   clr_d..clr_w pipeline register clears (F is never cleared)
//   mdu_cancel   one-cycle pulse that aborts an in-flight MDU operation
//   mdu_busy     high while waiting on the MDU
//   mdu_timeout  sticky watchdog flag; cleared only by reset

module pipe_hazard_ctrl #(
    parameter int unsigned MDU_MAX_CYC = 40,
    parameter int unsigned EXC_CYC     = 2,
    parameter int unsigned CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic lw_hazard_d,
    input  logic redirect_d,
    input  logic mdu_start_e,
    input  logic mdu_done,
    input  logic exc_m,
    output logic en_f,
    output logic en_d,
    output logic en_e,
    output logic en_m,
    output logic en_w,
    output logic clr_d,
    output logic clr_e,
    output logic clr_m,
    output logic clr_w,
    output logic mdu_cancel,
    output logic mdu_busy,
    output logic mdu_timeout
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU_WAIT  = 2'd1,
        EXC_FLUSH = 2'd2
    } state_e;

    // Counter value loaded on an exception, and the last MDU wait cycle
    // before the watchdog forces a release.
    localparam logic [CNT_W-1:0] EXC_LOAD = CNT_W'(EXC_CYC - 1);
    localparam logic [CNT_W-1:0] MDU_LAST = CNT_W'(MDU_MAX_CYC - 1);
    // A one-cycle flush is fully covered by the exception cycle itself.
    localparam state_e EXC_NEXT = (EXC_CYC > 1) ? EXC_FLUSH : RUN;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_inc, cnt_dec;

    // Saturating step values for the shared counter.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign cnt_dec = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (exc_m) begin
                    state_d = EXC_NEXT;
                    cnt_d   = EXC_LOAD;
                end else if (mdu_start_e) begin
                    state_d = MDU_WAIT;
                    cnt_d   = '0;
                end
            end
            MDU_WAIT: begin
                if (exc_m) begin
                    state_d = EXC_NEXT;
                    cnt_d   = EXC_LOAD;
                end else if (mdu_done) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= MDU_LAST) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            EXC_FLUSH: begin
                if (exc_m) begin
                    state_d = EXC_NEXT;
                    cnt_d   = EXC_LOAD;
                end else begin
                    // Leave once the decremented count reaches zero, so the
                    // total cleared cycles including the exception cycle
                    // equal EXC_CYC.
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic (Mealy)
    always_comb begin
        en_f       = 1'b1;
        en_d       = 1'b1;
        en_e       = 1'b1;
        en_m       = 1'b1;
        en_w       = 1'b1;
        clr_d      = 1'b0;
        clr_e      = 1'b0;
        clr_m      = 1'b0;
        clr_w      = 1'b0;
        mdu_cancel = 1'b0;
        mdu_busy   = 1'b0;
        if (!rst) begin
            clr_d = 1'b1;
            clr_e = 1'b1;
            clr_m = 1'b1;
            clr_w = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (exc_m) begin
                        clr_d = 1'b1;
                        clr_e = 1'b1;
                        clr_m = 1'b1;
                    end else if (mdu_start_e) begin
                        en_f  = 1'b0;
                        en_d  = 1'b0;
                        en_e  = 1'b0;
                        clr_m = 1'b1;
                    end else if (lw_hazard_d) begin
                        // Stall outranks redirect; the redirect is seen
                        // again once the stall resolves.
                        en_f  = 1'b0;
                        en_d  = 1'b0;
                        clr_e = 1'b1;
                    end else if (redirect_d) begin
                        clr_d = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    mdu_busy = 1'b1;
                    if (exc_m) begin
                        clr_d      = 1'b1;
                        clr_e      = 1'b1;
                        clr_m      = 1'b1;
                        mdu_cancel = 1'b1;
                    end else if (mdu_done) begin
                        // E advances with the MDU result.
                    end else if (cnt_q >= MDU_LAST) begin
                        mdu_cancel = 1'b1;
                    end else begin
                        en_f  = 1'b0;
                        en_d  = 1'b0;
                        en_e  = 1'b0;
                        clr_m = 1'b1;
                    end
                end
                EXC_FLUSH: begin
                    clr_d = 1'b1;
                    clr_e = 1'b1;
                    clr_m = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign mdu_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl. A behavioural model tracks
//   "MDU in progress with N cycles elapsed" and "flush cycles still owed",
//   and predicts every output each cycle. Directed scenarios also pin
//   literal output values, followed by a randomized run with sporadic resets.

module tb_pipe_hazard_ctrl;

    localparam int MAXC = 40;
    localparam int EXCC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, lw_hazard_d = 1'b0, redirect_d = 1'b0;
    logic mdu_start_e = 1'b0, mdu_done = 1'b0, exc_m = 1'b0;
    logic en_f, en_d, en_e, en_m, en_w;
    logic clr_d, clr_e, clr_m, clr_w;
    logic mdu_cancel, mdu_busy, mdu_timeout;

    pipe_hazard_ctrl #(.MDU_MAX_CYC(MAXC), .EXC_CYC(EXCC), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .lw_hazard_d(lw_hazard_d), .redirect_d(redirect_d),
        .mdu_start_e(mdu_start_e), .mdu_done(mdu_done), .exc_m(exc_m),
        .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
        .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m), .clr_w(clr_w),
        .mdu_cancel(mdu_cancel), .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout)
    );

    // {en_f,en_d,en_e,en_m,en_w, clr_d,clr_e,clr_m,clr_w, cancel,busy,timeout}
    logic [11:0] outs;
    assign outs = {en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w,
                   mdu_cancel, mdu_busy, mdu_timeout};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model + compare process ----------------
    bit         model_ok = 1'b0;
    bit         m_mdu    = 1'b0;  // MDU operation outstanding
    int         m_elapsed = 0;    // MDU wait cycles seen so far, incl. current
    int         m_owed   = 0;     // flush cycles still owed after this one
    bit         m_to     = 1'b0;
    logic [4:0] e_en;
    logic [3:0] e_clr;
    logic       e_can, e_busy, e_to;

    always @(negedge clk) begin
        e_en = 5'b11111; e_clr = 4'b0000; e_can = 1'b0; e_busy = 1'b0; e_to = m_to;
        if (!rst) begin
            e_clr = 4'b1111;
            m_mdu = 1'b0; m_owed = 0; m_to = 1'b0;
        end else if (m_owed > 0) begin
            e_clr = 4'b1110;
            m_owed = exc_m ? EXCC - 1 : m_owed - 1;
        end else if (m_mdu) begin
            e_busy = 1'b1;
            m_elapsed++;
            if (exc_m) begin
                e_clr = 4'b1110; e_can = 1'b1; m_mdu = 1'b0; m_owed = EXCC - 1;
            end else if (mdu_done) begin
                m_mdu = 1'b0;
            end else if (m_elapsed == MAXC) begin
                e_can = 1'b1; m_mdu = 1'b0; m_to = 1'b1;
            end else begin
                e_en = 5'b00011; e_clr = 4'b0010;
            end
        end else if (exc_m) begin
            e_clr = 4'b1110; m_owed = EXCC - 1;
        end else if (mdu_start_e) begin
            e_en = 5'b00011; e_clr = 4'b0010; m_mdu = 1'b1; m_elapsed = 0;
        end else if (lw_hazard_d) begin
            e_en = 5'b00111; e_clr = 4'b0100;
        end else if (redirect_d) begin
            e_clr = 4'b1000;
        end
        if (model_ok) check("model", outs, {e_en, e_clr, e_can, e_busy, e_to});
        if (!rst) model_ok = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic lw, input logic rd,
                       input logic st, input logic dn, input logic ex);
        @(posedge clk);
        #1;
        rst = r; lw_hazard_d = lw; redirect_d = rd;
        mdu_start_e = st; mdu_done = dn; exc_m = ex;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        int clr_cnt;
        bit seen;

        // 1. reset window, then idle
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_forced", outs, 12'b11111_1111_000);
        idle();
        check("idle_after_reset", outs, 12'b11111_0000_000);

        // 2. load-use bubble
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw_stall", outs, 12'b00111_0100_000);
        idle();
        check("lw_release", outs, 12'b11111_0000_000);

        // 3. MDU with done ten cycles after start
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mdu_start", outs, 12'b00011_0010_000);
        busy_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            idle();
            if (mdu_busy) busy_cnt++;
        end
        check("mdu_stall", outs, 12'b00011_0010_010);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (mdu_busy) busy_cnt++;
        check("mdu_done_release", outs, 12'b11111_0000_010);
        check_int("mdu_busy_cycles", busy_cnt, 10);
        idle();
        check("mdu_after_done", outs, 12'b11111_0000_000);

        // 4. watchdog: no done ever arrives (bounded wait)
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < MAXC + 20 && !seen; i++) begin
            idle();
            if (mdu_busy) busy_cnt++;
            if (mdu_cancel) begin
                seen = 1'b1;
                check("watchdog_fire", outs, 12'b11111_0000_110);
            end
        end
        check_int("watchdog_cycle", busy_cnt, MAXC);
        idle();
        check("watchdog_sticky", outs, 12'b11111_0000_001);

        // 5. exception during MDU wait, fifth wait cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("exc_in_mdu", outs, 12'b11111_1110_111);
        clr_cnt = 1;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (clr_d && clr_e && clr_m) clr_cnt++;
        end
        check_int("exc_clear_cycles", clr_cnt, EXCC);
        check("exc_done", outs, 12'b11111_0000_001);

        // 6. load-use + redirect together, then redirect alone
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lw_beats_redirect", outs, 12'b00111_0100_001);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("redirect_alone", outs, 12'b11111_1000_001);

        // exception while flushing reloads the flush length
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("exc_reload", outs, 12'b11111_1110_001);
        idle();
        check("exc_reload_tail", outs, 12'b11111_1110_001);
        idle();
        check("exc_reload_end", outs, 12'b11111_0000_001);

        // mid-flight reset: back to RUN, no cancel pulse, timeout cleared
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_mid_mdu", outs, 12'b11111_1111_001);
        idle();
        check("after_mid_reset", outs, 12'b11111_0000_000);

        // randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 24) == 0);
        end

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
